// File: rtl/swd_pkg.sv
// Shared constants for the SWD transfer sequencer: engine ACK codes, response
// status codes and the sequencer state encoding.
package swd_pkg;

   localparam logic [2:0] ACK_OK    = 3'b001;
   localparam logic [2:0] ACK_WAIT  = 3'b010;
   localparam logic [2:0] ACK_FAULT = 3'b100;

   localparam logic [2:0] ST_OK           = 3'd0;
   localparam logic [2:0] ST_WAIT_TIMEOUT = 3'd1;
   localparam logic [2:0] ST_FAULT        = 3'd2;
   localparam logic [2:0] ST_PROTERR      = 3'd3;
   localparam logic [2:0] ST_PARITY       = 3'd4;
   localparam logic [2:0] ST_ABORTED      = 3'd5;
   localparam logic [2:0] ST_NOMATCH      = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_BUSY,
      S_EVAL,
      S_RESP
   } xfer_state_e;

endpackage

// File: rtl/swd_xfer_seq.sv
// SWD transfer sequencer: one DP/AP request at a time, WAIT retry, result
// classification. Optional read value-match polling under SWD_XFER_VALMATCH_EN.
module swd_xfer_seq
   import swd_pkg::*;
#(
   parameter int unsigned RETRY_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_addr32,
   input  logic               req_rnw,
   input  logic               req_apndp,
   input  logic [31:0]        req_wdata,
   input  logic               abort,
   input  logic [RETRY_W-1:0] wait_retry,
`ifdef SWD_XFER_VALMATCH_EN
   input  logic               match_en,
   input  logic [31:0]        match_mask,
   input  logic [31:0]        match_val,
`endif
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [2:0]         rsp_status,
   output logic [31:0]        rsp_rdata,
   output logic [RETRY_W-1:0] rsp_retries,
   output logic               if_go,
   output logic [1:0]         if_addr32,
   output logic               if_rnw,
   output logic               if_apndp,
   output logic [31:0]        if_dwrite,
   input  logic [2:0]         if_ack,
   input  logic [31:0]        if_dread,
   input  logic               if_perr,
   input  logic               if_idle
);

   xfer_state_e        state_q;
   logic               req_ready_q;
   logic               rsp_valid_q;
   logic [2:0]         rsp_status_q;
   logic [31:0]        rsp_rdata_q;
   logic [RETRY_W-1:0] retries_q;
   logic               if_go_q;
   logic [1:0]         if_addr32_q;
   logic               if_rnw_q;
   logic               if_apndp_q;
   logic [31:0]        if_dwrite_q;
`ifdef SWD_XFER_VALMATCH_EN
   logic               match_en_q;
   logic [31:0]        match_mask_q;
   logic [31:0]        match_val_q;
`endif

   logic               can_retry_d;
   logic               reissue_d;
   logic [2:0]         status_d;
   logic [31:0]        rdata_d;

   // Only meaningful in S_EVAL: the engine holds ack/dread/perr while idle.
   always_comb begin
      can_retry_d = (retries_q < wait_retry);
      reissue_d   = 1'b0;
      status_d    = ST_OK;
      rdata_d     = '0;
      if (if_ack == ACK_WAIT) begin
         if (abort)
            status_d = ST_ABORTED;
         else if (can_retry_d)
            reissue_d = 1'b1;
         else
            status_d = ST_WAIT_TIMEOUT;
      end else if (if_ack == ACK_FAULT) begin
         status_d = ST_FAULT;
      end else if (if_ack != ACK_OK) begin
         status_d = ST_PROTERR;
      end else if (if_rnw_q && if_perr) begin
         status_d = ST_PARITY;
         rdata_d  = if_dread;
`ifdef SWD_XFER_VALMATCH_EN
      end else if (if_rnw_q && match_en_q &&
                   ((if_dread & match_mask_q) != match_val_q)) begin
         rdata_d = if_dread;
         if (can_retry_d)
            reissue_d = 1'b1;
         else
            status_d = ST_NOMATCH;
`endif
      end else begin
         status_d = ST_OK;
         rdata_d  = if_rnw_q ? if_dread : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         req_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_status_q <= '0;
         rsp_rdata_q  <= '0;
         retries_q    <= '0;
         if_go_q      <= 1'b0;
         if_addr32_q  <= '0;
         if_rnw_q     <= 1'b0;
         if_apndp_q   <= 1'b0;
         if_dwrite_q  <= '0;
`ifdef SWD_XFER_VALMATCH_EN
         match_en_q   <= 1'b0;
         match_mask_q <= '0;
         match_val_q  <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               req_ready_q <= 1'b1;
               if (req_valid && req_ready_q) begin
                  req_ready_q  <= 1'b0;
                  if_addr32_q  <= req_addr32;
                  if_rnw_q     <= req_rnw;
                  if_apndp_q   <= req_apndp;
                  if_dwrite_q  <= req_wdata;
`ifdef SWD_XFER_VALMATCH_EN
                  match_en_q   <= match_en;
                  match_mask_q <= match_mask;
                  match_val_q  <= match_val;
`endif
                  retries_q    <= '0;
                  if_go_q      <= 1'b1;
                  state_q      <= S_ISSUE;
               end
            end
            // go is held until the engine leaves idle; it only acts on the rising strobe.
            S_ISSUE: begin
               if (!if_idle) begin
                  if_go_q <= 1'b0;
                  state_q <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (if_idle)
                  state_q <= S_EVAL;
            end
            S_EVAL: begin
               if (reissue_d) begin
                  retries_q <= retries_q + 1'b1;
                  if_go_q   <= 1'b1;
                  state_q   <= S_ISSUE;
               end else begin
                  rsp_status_q <= status_d;
                  rsp_rdata_q  <= rdata_d;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_status  = rsp_status_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_retries = retries_q;
   assign if_go       = if_go_q;
   assign if_addr32   = if_addr32_q;
   assign if_rnw      = if_rnw_q;
   assign if_apndp    = if_apndp_q;
   assign if_dwrite   = if_dwrite_q;

endmodule
